// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-cycle reads to an instruction RAM and
// buffers the returned words in a small prefetch queue feeding the decode stage.
module fetch_unit #(
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    DATA_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 16'h0100,
   parameter int                    QUEUE_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_cs,
   output logic                  mem_oe,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  halt,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [ADDR_WIDTH-1:0]   fetch_pc_r;
   logic [ADDR_WIDTH-1:0]   req_pc_r;
   logic                    inflight_r;
   logic [CNT_W-1:0]        count_r;
   logic [PTR_W-1:0]        rd_ptr_r;
   logic [PTR_W-1:0]        wr_ptr_r;
   logic [DATA_WIDTH-1:0]   q_data_r [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0]   q_pc_r   [QUEUE_DEPTH];
   logic [DATA_WIDTH-1:0]   instr_r;
   logic [ADDR_WIDTH-1:0]   instr_pc_r;

   logic                    pop_s;
   logic                    push_s;
   logic                    req_s;
   logic                    head_push_s;
   logic [CNT_W-1:0]        occ_s;
   logic [CNT_W-1:0]        count_nxt_s;
   logic [PTR_W-1:0]        rd_ptr_inc_s;

   // Handshake, occupancy and request decision for the current cycle
   always_comb begin
      pop_s        = 1'b0;
      push_s       = 1'b0;
      req_s        = 1'b0;
      head_push_s  = 1'b0;
      occ_s        = count_r;
      count_nxt_s  = count_r;
      rd_ptr_inc_s = rd_ptr_r + PTR_W'(1'b1);

      pop_s  = (count_r != {CNT_W{1'b0}}) && instr_ready;
      // a response landing in the redirect cycle belongs to the old stream
      push_s = inflight_r && !redirect;
      // a pop this cycle already frees the slot the new request will need
      occ_s  = count_r + CNT_W'(inflight_r) - CNT_W'(pop_s);
      if (!rst && !halt && !redirect && (state_r == ST_FETCH) &&
          (occ_s < CNT_W'(QUEUE_DEPTH))) begin
         req_s = 1'b1;
      end else begin
         req_s = 1'b0;
      end
      count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      head_push_s = push_s && ((count_r - CNT_W'(pop_s)) == {CNT_W{1'b0}});
   end

   // Next-state logic: redirect wins, and a redirect while halted stays halted
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_FETCH: begin
            if (redirect)  state_nxt_s = ST_FLUSH;
            else if (halt) state_nxt_s = ST_HALTED;
            else           state_nxt_s = ST_FETCH;
         end
         ST_FLUSH: begin
            if (redirect)  state_nxt_s = ST_FLUSH;
            else if (halt) state_nxt_s = ST_HALTED;
            else           state_nxt_s = ST_FETCH;
         end
         ST_HALTED: begin
            if (redirect || halt) state_nxt_s = ST_HALTED;
            else                  state_nxt_s = ST_FETCH;
         end
         default: state_nxt_s = ST_FETCH;
      endcase
   end

   // Control state, pointers, fetch address and registered head of queue
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_FETCH;
         fetch_pc_r <= RESET_PC;
         req_pc_r   <= RESET_PC;
         inflight_r <= 1'b0;
         count_r    <= {CNT_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         wr_ptr_r   <= {PTR_W{1'b0}};
         instr_r    <= {DATA_WIDTH{1'b0}};
         instr_pc_r <= {ADDR_WIDTH{1'b0}};
      end else if (redirect) begin
         state_r    <= state_nxt_s;
         fetch_pc_r <= redirect_pc;
         inflight_r <= 1'b0;
         count_r    <= {CNT_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         wr_ptr_r   <= {PTR_W{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         inflight_r <= req_s;
         count_r    <= count_nxt_s;
         if (req_s) begin
            fetch_pc_r <= fetch_pc_r + ADDR_WIDTH'(1'b1);
            req_pc_r   <= fetch_pc_r;
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_inc_s;
         end
         // output words only move when the head changes; empty keeps the last one
         if (head_push_s) begin
            instr_r    <= mem_rdata;
            instr_pc_r <= req_pc_r;
         end else if (pop_s && (count_nxt_s != {CNT_W{1'b0}})) begin
            instr_r    <= q_data_r[rd_ptr_inc_s];
            instr_pc_r <= q_pc_r[rd_ptr_inc_s];
         end
      end
   end

   // Queue storage, written at the tail when a response is accepted
   always_ff @(posedge clk) begin
      if (!rst && push_s) begin
         q_data_r[wr_ptr_r] <= mem_rdata;
         q_pc_r[wr_ptr_r]   <= req_pc_r;
      end
   end

   assign mem_addr    = fetch_pc_r;
   assign mem_cs      = req_s;
   assign mem_oe      = req_s;
   assign instr       = instr_r;
   assign instr_pc    = instr_pc_r;
   assign instr_valid = (count_r != {CNT_W{1'b0}});

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a one-cycle-latency RAM model feeds the unit and
// every observation is compared against hand-derived values.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mem_addr;
   logic        mem_cs;
   logic        mem_oe;
   logic [15:0] mem_rdata;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;

   int checks_cnt = 0;
   int errors_cnt = 0;
   int req_cnt    = 0;

   logic [15:0] exp_words [4];

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .mem_addr    (mem_addr),
      .mem_cs      (mem_cs),
      .mem_oe      (mem_oe),
      .mem_rdata   (mem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ram_word(input logic [15:0] a);
      case (a)
         16'h0100: ram_word = 16'h110C;
         16'h0101: ram_word = 16'h210E;
         16'h0102: ram_word = 16'h110D;
         16'h0103: ram_word = 16'h310B;
         default:  ram_word = a ^ 16'hC000;
      endcase
   endfunction

   // RAM model: data one cycle after a request, garbage otherwise
   always @(posedge clk) begin
      mem_rdata <= mem_cs ? ram_word(mem_addr) : 16'hDEAD;
   end

   // request counter
   always @(negedge clk) begin
      if (mem_cs) req_cnt <= req_cnt + 1;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      halt        = 1'b0;
      instr_ready = rdy;
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_words[0] = 16'h110C;
      exp_words[1] = 16'h210E;
      exp_words[2] = 16'h110D;
      exp_words[3] = 16'h310B;

      // reset values, then streaming with decode always ready
      do_reset(1'b1);
      check_value("rst_valid", 32'(instr_valid), 32'h0);
      check_value("rst_instr", 32'(instr), 32'h0);
      check_value("rst_pc",    32'(instr_pc), 32'h0);
      check_value("rst_cs",    32'(mem_cs), 32'h0);
      check_value("rst_oe",    32'(mem_oe), 32'h0);
      check_value("rst_addr",  32'(mem_addr), 32'h100);
      rst = 1'b0;
      #1;
      check_value("c0_cs",    32'(mem_cs), 32'h1);
      check_value("c0_oe",    32'(mem_oe), 32'h1);
      check_value("c0_addr",  32'(mem_addr), 32'h100);
      check_value("c0_valid", 32'(instr_valid), 32'h0);
      tick();
      check_value("c1_addr",  32'(mem_addr), 32'h101);
      check_value("c1_cs",    32'(mem_cs), 32'h1);
      check_value("c1_valid", 32'(instr_valid), 32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         check_value("stream_valid", 32'(instr_valid), 32'h1);
         check_value("stream_instr", 32'(instr), 32'(exp_words[i]));
         check_value("stream_pc",    32'(instr_pc), 32'h100 + 32'(i));
         tick();
      end

      // decode stalled: queue fills with exactly four requests, then drains
      do_reset(1'b0);
      rst = 1'b0;
      req_cnt = 0;
      #1;
      repeat (10) tick();
      check_value("stall_reqs",  32'(req_cnt), 32'd4);
      check_value("stall_cs",    32'(mem_cs), 32'h0);
      check_value("stall_valid", 32'(instr_valid), 32'h1);
      check_value("stall_instr", 32'(instr), 32'h110C);
      check_value("stall_pc",    32'(instr_pc), 32'h100);
      instr_ready = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         check_value("drain_valid", 32'(instr_valid), 32'h1);
         check_value("drain_instr", 32'(instr), (i < 4) ? 32'(exp_words[i]) : 32'hC104);
         check_value("drain_pc",    32'(instr_pc), 32'h100 + 32'(i));
         tick();
      end

      // redirect with three queued entries and a response in flight
      do_reset(1'b0);
      rst = 1'b0;
      #1;
      repeat (4) tick();
      check_value("full_cs", 32'(mem_cs), 32'h0);
      redirect    = 1'b1;
      redirect_pc = 16'h0109;
      #1;
      check_value("redir_cs", 32'(mem_cs), 32'h0);
      tick();
      redirect = 1'b0;
      #1;
      check_value("flush_valid", 32'(instr_valid), 32'h0);
      check_value("flush_cs",    32'(mem_cs), 32'h0);
      tick();
      check_value("refetch_cs",   32'(mem_cs), 32'h1);
      check_value("refetch_addr", 32'(mem_addr), 32'h109);
      instr_ready = 1'b1;
      tick();
      tick();
      check_value("redir_valid", 32'(instr_valid), 32'h1);
      check_value("redir_pc",    32'(instr_pc), 32'h109);
      check_value("redir_instr", 32'(instr), 32'hC109);

      // address wrap at the top of the space
      redirect    = 1'b1;
      redirect_pc = 16'hFFFF;
      #1;
      tick();
      redirect = 1'b0;
      #1;
      check_value("wrap_flush_valid", 32'(instr_valid), 32'h0);
      tick();
      check_value("wrap_addr0", 32'(mem_addr), 32'hFFFF);
      check_value("wrap_cs0",   32'(mem_cs), 32'h1);
      tick();
      check_value("wrap_addr1", 32'(mem_addr), 32'h0000);
      check_value("wrap_cs1",   32'(mem_cs), 32'h1);
      tick();
      check_value("wrap_pc0",    32'(instr_pc), 32'hFFFF);
      check_value("wrap_instr0", 32'(instr), 32'h3FFF);
      tick();
      check_value("wrap_pc1",    32'(instr_pc), 32'h0000);
      check_value("wrap_instr1", 32'(instr), 32'hC000);

      // halt during a request: response still delivered, then resume
      do_reset(1'b1);
      rst = 1'b0;
      #1;
      tick();
      halt = 1'b1;
      #1;
      check_value("halt_cs1", 32'(mem_cs), 32'h0);
      tick();
      check_value("halt_valid", 32'(instr_valid), 32'h1);
      check_value("halt_instr", 32'(instr), 32'h110C);
      check_value("halt_cs2",   32'(mem_cs), 32'h0);
      tick();
      check_value("halt_drained", 32'(instr_valid), 32'h0);
      check_value("halt_cs3",     32'(mem_cs), 32'h0);
      halt = 1'b0;
      #1;
      check_value("unhalt_cs", 32'(mem_cs), 32'h0);
      tick();
      check_value("resume_cs",   32'(mem_cs), 32'h1);
      check_value("resume_addr", 32'(mem_addr), 32'h101);
      tick();
      tick();
      check_value("resume_pc",    32'(instr_pc), 32'h101);
      check_value("resume_instr", 32'(instr), 32'h210E);

      // reset with a full queue and a response in flight
      do_reset(1'b0);
      rst = 1'b0;
      #1;
      repeat (4) tick();
      rst = 1'b1;
      redirect = 1'b1;
      redirect_pc = 16'h0200;
      #1;
      check_value("rstmid_cs", 32'(mem_cs), 32'h0);
      tick();
      redirect = 1'b0;
      check_value("rstmid_valid", 32'(instr_valid), 32'h0);
      check_value("rstmid_instr", 32'(instr), 32'h0);
      check_value("rstmid_pc",    32'(instr_pc), 32'h0);
      check_value("rstmid_addr",  32'(mem_addr), 32'h100);
      rst = 1'b0;
      instr_ready = 1'b1;
      #1;
      check_value("rstrel_cs",   32'(mem_cs), 32'h1);
      check_value("rstrel_addr", 32'(mem_addr), 32'h100);
      tick();
      tick();
      check_value("rstrel_valid", 32'(instr_valid), 32'h1);
      check_value("rstrel_instr", 32'(instr), 32'h110C);
      check_value("rstrel_pc",    32'(instr_pc), 32'h100);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
